// File: rtl/ins_fetch_if.sv
// ins_fetch_if: icache, decoder, ROB and branch-update signals around the fetch unit
interface ins_fetch_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_data;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        isjump;
  logic        stall;
  logic        dc_valid;
  logic [31:0] dc_nextpc;
  logic        rob_clear;
  logic [31:0] rob_newpc;
  logic        br_update;
  logic [31:0] br_pc;
  logic        br_taken;
  modport master (
    output ic_req, ic_addr, if_valid, instr, pc, isjump,
    input  ic_valid, ic_data, stall, dc_valid, dc_nextpc,
           rob_clear, rob_newpc, br_update, br_pc, br_taken
  );
  modport slave (
    input  ic_req, ic_addr, if_valid, instr, pc, isjump,
    output ic_valid, ic_data, stall, dc_valid, dc_nextpc,
           rob_clear, rob_newpc, br_update, br_pc, br_taken
  );
endinterface

// File: rtl/ins_fetch.sv
// ins_fetch: one-instruction-at-a-time fetch with a 64-entry 2-bit branch history table
module ins_fetch (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  ins_fetch_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_fetch_pc, r_instr, r_pc;
  logic        r_if_valid, r_isjump;
  logic [1:0]  r_bht [64];
  logic        w_req, w_capture, w_accept, w_unused;
  logic [5:0]  w_uidx;
  // request is combinational so it lasts exactly the single IDLE cycle and drops while frozen
  assign w_req     = rst_in & rdy_in & ~bus.rob_clear & (r_state == S_IDLE);
  assign w_capture = (r_state == S_WAIT) & bus.ic_valid & ~bus.rob_clear;
  assign w_accept  = (r_state == S_HOLD) & bus.dc_valid & ~bus.rob_clear;
  assign w_uidx    = bus.br_pc[7:2];
  assign w_unused  = ^{bus.stall, bus.br_pc[31:8], bus.br_pc[1:0]};
  assign bus.ic_req   = w_req;
  assign bus.ic_addr  = w_req ? r_fetch_pc : '0;
  assign bus.if_valid = r_if_valid;
  assign bus.instr    = r_instr;
  assign bus.pc       = r_pc;
  assign bus.isjump   = r_isjump;
  // next state; a flush in WAIT must still swallow the in-flight response unless it lands now
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_req ? S_WAIT : S_IDLE;
      S_WAIT:  w_next = bus.rob_clear ? (bus.ic_valid ? S_IDLE : S_DRAIN)
                                      : (bus.ic_valid ? S_HOLD : S_WAIT);
      S_HOLD:  w_next = (bus.rob_clear | bus.dc_valid) ? S_IDLE : S_HOLD;
      default: w_next = bus.ic_valid ? S_IDLE : S_DRAIN;
    endcase
  end
  // state register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_next;
  end
  // fetch pointer and presented instruction; flush outranks decoder acceptance
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_fetch_pc <= '0;
      r_if_valid <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_isjump   <= 1'b0;
    end else if (rdy_in) begin
      if (bus.rob_clear) begin
        r_fetch_pc <= bus.rob_newpc;
        r_if_valid <= 1'b0;
      end else if (w_accept) begin
        r_fetch_pc <= bus.dc_nextpc;
        r_if_valid <= 1'b0;
      end else if (w_capture) begin
        r_instr    <= bus.ic_data;
        r_pc       <= r_fetch_pc;
        r_if_valid <= 1'b1;
        r_isjump   <= (bus.ic_data[6:0] == 7'b1100011) & r_bht[r_fetch_pc[7:2]][1];
      end
    end
  end
  // branch history counters; lookup above reads the value before this update lands
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 64; i++) r_bht[i] <= 2'b01;
    end else if (rdy_in && bus.br_update) begin
      r_bht[w_uidx] <= bus.br_taken ? ((r_bht[w_uidx] == 2'b11) ? 2'b11 : r_bht[w_uidx] + 2'b01)
                                    : ((r_bht[w_uidx] == 2'b00) ? 2'b00 : r_bht[w_uidx] - 2'b01);
    end
  end
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: directed scenarios plus randomized fetch traffic against a transaction-level model
module tb_ins_fetch;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  ins_fetch_if bus ();
  ins_fetch dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  int n_chk = 0;
  int n_pass = 0;
  int bht [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic model_reset();
    foreach (bht[i]) bht[i] = 1;
  endtask

  function automatic logic pred(input logic [31:0] a, input logic [31:0] d);
    return (d[6:0] == 7'b1100011) && (bht[a[7:2]] >= 2);
  endfunction

  task automatic model_br(input logic [31:0] a, input logic t);
    int i;
    i = int'(a[7:2]);
    bht[i] = t ? ((bht[i] + 1 > 3) ? 3 : bht[i] + 1) : ((bht[i] - 1 < 0) ? 0 : bht[i] - 1);
  endtask

  task automatic br(input logic [31:0] a, input logic t);
    bus.br_update = 1'b1; bus.br_pc = a; bus.br_taken = t;
    cyc();
    bus.br_update = 1'b0;
    model_br(a, t);
  endtask

  task automatic wait_req(input logic [31:0] a);
    int k;
    k = 0;
    #1;
    while (bus.ic_req !== 1'b1 && k < 20) begin cyc(); #1; k++; end
    chk("ic_req", bus.ic_req, 1);
    chk("ic_addr", bus.ic_addr, a);
  endtask

  task automatic respond(input logic [31:0] a, input logic [31:0] d, input int dly,
                         input logic do_br, input logic [31:0] ba, input logic bt);
    logic p;
    cyc();
    repeat (dly - 1) begin chk("req_in_wait", bus.ic_req, 0); cyc(); end
    p = pred(a, d);
    bus.ic_valid = 1'b1; bus.ic_data = d;
    bus.br_update = do_br; bus.br_pc = ba; bus.br_taken = bt;
    cyc();
    bus.ic_valid = 1'b0; bus.br_update = 1'b0;
    if (do_br) model_br(ba, bt);
    chk("if_valid", bus.if_valid, 1);
    chk("instr", bus.instr, d);
    chk("pc", bus.pc, a);
    chk("isjump", bus.isjump, p);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int dly);
    wait_req(a);
    respond(a, d, dly, 1'b0, '0, 1'b0);
  endtask

  task automatic stable(input string tag, input logic [31:0] a, input logic [31:0] d, input logic p);
    chk({tag, "_if_valid"}, bus.if_valid, 1);
    chk({tag, "_instr"}, bus.instr, d);
    chk({tag, "_pc"}, bus.pc, a);
    chk({tag, "_isjump"}, bus.isjump, p);
    chk({tag, "_no_req"}, bus.ic_req, 0);
  endtask

  task automatic accept(input logic [31:0] n);
    bus.dc_valid = 1'b1; bus.dc_nextpc = n;
    cyc();
    bus.dc_valid = 1'b0;
    chk("if_drop", bus.if_valid, 0);
  endtask

  initial begin
    logic [31:0] cur, nx, nx2, d, ba;
    logic p;
    int h;
    bus.ic_valid = 0; bus.ic_data = 0; bus.stall = 0; bus.dc_valid = 0; bus.dc_nextpc = 0;
    bus.rob_clear = 0; bus.rob_newpc = 0; bus.br_update = 0; bus.br_pc = 0; bus.br_taken = 0;
    rdy_in = 1'b1; rst_in = 1'b0;
    model_reset();
    repeat (2) cyc();
    chk("rst_ic_req", bus.ic_req, 0);
    chk("rst_ic_addr", bus.ic_addr, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_isjump", bus.isjump, 0);
    rst_in = 1'b1;
    // first fetch from 0 after reset, then decoder redirects to 4
    fetch(32'h0, 32'h00000013, 2);
    accept(32'h4);
    fetch(32'h4, 32'h00000033, 1);
    accept(32'h40);
    // branch prediction warm-up at 0x40
    fetch(32'h40, 32'h00000463, 1);
    br(32'h40, 1'b1);
    br(32'h40, 1'b1);
    stable("hold_after_br", 32'h40, 32'h00000463, 1'b0);
    accept(32'h40);
    fetch(32'h40, 32'h00000463, 3);
    repeat (3) br(32'h40, 1'b1);
    br(32'h40, 1'b0);
    accept(32'h40);
    wait_req(32'h40);
    respond(32'h40, 32'h00000463, 1, 1'b1, 32'h40, 1'b0);
    accept(32'h40);
    fetch(32'h40, 32'h00000463, 2);
    accept(32'h80);
    // flush while waiting; the late response must be swallowed
    wait_req(32'h80);
    cyc();
    bus.rob_clear = 1'b1; bus.rob_newpc = 32'h100;
    cyc();
    bus.rob_clear = 1'b0;
    repeat (2) begin
      chk("drain_no_req", bus.ic_req, 0);
      chk("drain_no_valid", bus.if_valid, 0);
      cyc();
    end
    bus.ic_valid = 1'b1; bus.ic_data = 32'h00000013;
    cyc();
    bus.ic_valid = 1'b0;
    chk("drain_dropped", bus.if_valid, 0);
    // flush wins over decoder acceptance in the same cycle
    fetch(32'h100, 32'h00000093, 2);
    bus.rob_clear = 1'b1; bus.rob_newpc = 32'h200;
    bus.dc_valid = 1'b1; bus.dc_nextpc = 32'h300;
    cyc();
    bus.rob_clear = 1'b0; bus.dc_valid = 1'b0;
    chk("clr_if_drop", bus.if_valid, 0);
    // long hold, pump counter 16 to max, then freeze with rdy low
    fetch(32'h200, 32'h00000113, 1);
    repeat (10) begin cyc(); stable("hold", 32'h200, 32'h00000113, 1'b0); end
    br(32'h40, 1'b1);
    br(32'h40, 1'b1);
    rdy_in = 1'b0;
    bus.dc_valid = 1'b1; bus.dc_nextpc = 32'h999;
    repeat (3) begin cyc(); stable("frozen", 32'h200, 32'h00000113, 1'b0); end
    bus.dc_valid = 1'b0;
    rdy_in = 1'b1;
    accept(32'h240);
    rdy_in = 1'b0;
    #1;
    chk("frozen_idle_req", bus.ic_req, 0);
    repeat (2) begin cyc(); chk("frozen_idle_req", bus.ic_req, 0); end
    rdy_in = 1'b1;
    wait_req(32'h240);
    cyc();
    rdy_in = 1'b0;
    bus.ic_valid = 1'b1; bus.ic_data = 32'h00000193;
    cyc();
    bus.ic_valid = 1'b0;
    cyc();
    rdy_in = 1'b1;
    chk("frozen_not_captured", bus.if_valid, 0);
    respond(32'h240, 32'h00000213, 2, 1'b0, '0, 1'b0);
    accept(32'h44);
    // reset in the middle of a request
    wait_req(32'h44);
    cyc();
    rst_in = 1'b0;
    #1;
    chk("midrst_req", bus.ic_req, 0);
    chk("midrst_if_valid", bus.if_valid, 0);
    model_reset();
    cyc();
    rst_in = 1'b1;
    fetch(32'h0, 32'h00000063, 1);
    accept(32'h40);
    fetch(32'h40, 32'h00000463, 1);
    accept(32'h0);
    cur = 32'h0;
    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[6:0] = 7'b1100011;
      else if (d[6:0] == 7'b1100011) d[0] = 1'b0;
      ba = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
      wait_req(cur);
      respond(cur, d, $urandom_range(1, 4), 1'($urandom_range(0, 1)), ba, 1'($urandom_range(0, 1)));
      p = bus.isjump === pred(cur, d) ? bus.isjump : pred(cur, d);
      h = $urandom_range(0, 3);
      repeat (h) begin
        if ($urandom_range(0, 1) == 1) begin
          ba = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
          br(ba, 1'($urandom_range(0, 1)));
        end else cyc();
        chk("rnd_hold_instr", bus.instr, d);
        chk("rnd_hold_pc", bus.pc, cur);
        chk("rnd_hold_valid", bus.if_valid, 1);
      end
      nx  = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
      nx2 = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
      if ($urandom_range(0, 5) == 0) begin
        bus.rob_clear = 1'b1; bus.rob_newpc = nx2;
        bus.dc_valid = 1'($urandom_range(0, 1)); bus.dc_nextpc = nx;
        cyc();
        bus.rob_clear = 1'b0; bus.dc_valid = 1'b0;
        chk("rnd_clr_drop", bus.if_valid, 0);
        cur = nx2;
      end else begin
        accept(nx);
        cur = nx;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
